// File: rtl/reservation_alu3_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : reservation_alu3_scheduler                                 |
// | Description : Allocation and in-order issue control for the ALU3         |
// |               reservation station. It picks a free entry for dispatch,   |
// |               picks the lowest ready entry for issue, keeps the in-order |
// |               tag pointers and occupancy count, and sequences a flush.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module reservation_alu3_scheduler #(
  parameter int ENTRY_N = 4
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iFLUSH,
  input  logic               iREGIST_VALID,
  output logic               oREGIST_FULL,
  output logic [ENTRY_N-1:0] oENTRY_REGIST,
  output logic [3:0]         oEX_REGIST_POINTER,
  input  logic [ENTRY_N-1:0] iENTRY_VALID,
  input  logic [ENTRY_N-1:0] iENTRY_MATCHING,
  input  logic               iEX_BUSY,
  output logic [ENTRY_N-1:0] oENTRY_EXOUT,
  output logic [3:0]         oEX_EXECUTION_POINTER,
  output logic               oEX_VALID,
  output logic [1:0]         oEX_SEL,
  output logic               oREMOVE_VALID,
  output logic [2:0]         oCOUNT
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [ENTRY_N-1:0] ONE = {{(ENTRY_N-1){1'b0}}, 1'b1};

  state_t             state;
  logic [3:0]         reg_ptr;
  logic [3:0]         exe_ptr;
  logic [2:0]         count;
  logic               ex_valid;
  logic [1:0]         ex_sel;

  logic               flushing;
  logic               full;
  logic [ENTRY_N-1:0] free_vec;
  logic [ENTRY_N-1:0] ready_vec;
  logic [ENTRY_N-1:0] regist_vec;
  logic [ENTRY_N-1:0] exout_vec;
  logic [1:0]         exout_idx;
  logic               do_regist;
  logic               do_issue;

  // Entry selection: lowest free slot for dispatch, lowest ready slot for issue.
  // A matching entry that is not valid is never considered ready.
  always_comb begin
    flushing   = iFLUSH | (state == FLUSH);
    full       = flushing | (&iENTRY_VALID);
    free_vec   = ~iENTRY_VALID;
    ready_vec  = iENTRY_MATCHING & iENTRY_VALID;
    regist_vec = '0;
    exout_vec  = '0;
    if (iREGIST_VALID && !full) begin
      regist_vec = free_vec & (~free_vec + ONE);
    end
    if (!iEX_BUSY && !flushing) begin
      exout_vec = ready_vec & (~ready_vec + ONE);
    end
    do_regist = |regist_vec;
    do_issue  = |exout_vec;
  end

  // One-hot to index for the issue payload mux select.
  always_comb begin
    exout_idx = 2'd0;
    for (int i = 0; i < ENTRY_N; i++) begin
      if (exout_vec[i]) begin
        exout_idx = i[1:0];
      end
    end
  end

  // Flush sequencing, tag pointers, occupancy and the registered issue port.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state    <= RUN;
      reg_ptr  <= 4'd0;
      exe_ptr  <= 4'd0;
      count    <= 3'd0;
      ex_valid <= 1'b0;
      ex_sel   <= 2'd0;
    end else if (iFLUSH) begin
      // Whatever was offered this cycle is discarded along with the entries.
      state    <= (state == RUN) ? FLUSH : RUN;
      reg_ptr  <= 4'd0;
      exe_ptr  <= 4'd0;
      count    <= 3'd0;
      ex_valid <= 1'b0;
    end else begin
      state    <= RUN;
      ex_valid <= do_issue;
      if (do_issue) begin
        ex_sel  <= exout_idx;
        exe_ptr <= exe_ptr + 4'd1;
      end
      if (do_regist) begin
        reg_ptr <= reg_ptr + 4'd1;
      end
      if (do_regist && !do_issue) begin
        count <= count + 3'd1;
      end else if (!do_regist && do_issue) begin
        count <= count - 3'd1;
      end
    end
  end

  assign oREMOVE_VALID         = iFLUSH & (state == RUN);
  assign oREGIST_FULL          = full;
  assign oENTRY_REGIST         = regist_vec;
  assign oENTRY_EXOUT          = exout_vec;
  assign oEX_REGIST_POINTER    = reg_ptr;
  assign oEX_EXECUTION_POINTER = exe_ptr;
  assign oEX_VALID             = ex_valid;
  assign oEX_SEL               = ex_sel;
  assign oCOUNT                = count;

endmodule
`default_nettype wire

// File: doc/reservation_alu3_scheduler.md
RESERVATION_ALU3_SCHEDULER -- requirements
Module: reservation_alu3_scheduler

Interface
REQ-001 SHALL have parameter ENTRY_N, default 4, number of reservation entries driven (fixed 4 in this revision).
REQ-002 SHALL have port iCLOCK  in  1  clock, rising edge.
REQ-003 SHALL have port inRESET  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port iFLUSH  in  1  pipeline flush request, single-cycle pulse.
REQ-005 SHALL have port iREGIST_VALID  in  1  dispatch offers one instruction this cycle.
REQ-006 SHALL have port oREGIST_FULL  out  1  no entry can accept; dispatch must hold.
REQ-007 SHALL have port oENTRY_REGIST  out  4  one-hot entry-load strobe (per-entry iREGIST_VALID).
REQ-008 SHALL have port oEX_REGIST_POINTER  out  4  in-order tag given to the loading entry.
REQ-009 SHALL have port iENTRY_VALID  in  4  per-entry oINFO_ENTRY_VALID.
REQ-010 SHALL have port iENTRY_MATCHING  in  4  per-entry oINFO_MATCHING.
REQ-011 SHALL have port iEX_BUSY  in  1  ALU3 execution stage cannot accept.
REQ-012 SHALL have port oENTRY_EXOUT  out  4  one-hot issue strobe (per-entry iEXOUT_VALID).
REQ-013 SHALL have port oEX_EXECUTION_POINTER  out  4  current in-order execution pointer to all entries.
REQ-014 SHALL have port oEX_VALID  out  1  registered issue-valid to execution stage.
REQ-015 SHALL have port oEX_SEL  out  2  registered index of issued entry (payload mux select).
REQ-016 SHALL have port oREMOVE_VALID  out  1  flush strobe to all entries (iREMOVE_VALID).
REQ-017 SHALL have port oCOUNT  out  3  occupied entries, 0..4.

Function
REQ-018 SHALL implement states RUN and FLUSH; RUN->FLUSH on iFLUSH; FLUSH->RUN unconditionally after one cycle.
REQ-019 SHALL drive oREMOVE_VALID = iFLUSH combinationally; oREMOVE_VALID 0 in FLUSH state.
REQ-020 SHALL force oREGIST_FULL=1, oENTRY_REGIST=0, oENTRY_EXOUT=0 while iFLUSH=1 or state=FLUSH.
REQ-021 SHALL, in RUN, assert oREGIST_FULL when iENTRY_VALID==4'b1111, else 0.
REQ-022 SHALL, in RUN with iREGIST_VALID=1 and not full, set oENTRY_REGIST to lowest-index bit with iENTRY_VALID=0 (combinational, same cycle).
REQ-023 SHALL drive oEX_REGIST_POINTER from 4-bit register reg_ptr; reg_ptr increments mod 16 on each cycle oENTRY_REGIST!=0.
REQ-024 SHALL drive oEX_EXECUTION_POINTER from 4-bit register exe_ptr; exe_ptr increments mod 16 on each cycle oENTRY_EXOUT!=0.
REQ-025 SHALL, in RUN with iEX_BUSY=0, set oENTRY_EXOUT to lowest-index bit of (iENTRY_MATCHING & iENTRY_VALID); 0 when none or iEX_BUSY=1.
REQ-026 SHALL register oEX_VALID<=|oENTRY_EXOUT and oEX_SEL<=encoded index each edge (issue latency 1 cycle); oEX_SEL holds when no issue.
REQ-027 SHALL update count: +1 on regist only, -1 on issue only, unchanged on both or neither; oCOUNT = count.
REQ-028 SHALL allow regist and issue in the same cycle, including into/from different entries when full→issue frees none until next edge (full blocks regist that cycle).
REQ-029 SHALL, on the edge where iFLUSH=1, clear reg_ptr, exe_ptr, count to 0 and oEX_VALID to 0, discarding any same-cycle regist/issue.
REQ-030 SHALL treat a MATCHING bit with VALID=0 as not ready.

Reset
REQ-031 SHALL on inRESET=0 asynchronously set state=RUN, reg_ptr=0, exe_ptr=0, count=0, oEX_VALID=0, oEX_SEL=0.
REQ-032 SHALL hold all combinational strobes (oENTRY_REGIST, oENTRY_EXOUT, oREMOVE_VALID) at 0 while in reset if iFLUSH=0 and inputs are 0.
REQ-033 SHALL apply reset mid-operation identically, with no issue or regist completing on the reset edge.

Verification
REQ-034 SHALL verify: reset, iREGIST_VALID=1 for 4 cycles with ENTRY_VALID tracking -> oENTRY_REGIST 0001,0010,0100,1000; pointers 0..3; oCOUNT=4; oREGIST_FULL=1.
REQ-035 SHALL verify: ENTRY_MATCHING=0110, VALID=1111, EX_BUSY=0 -> oENTRY_EXOUT=0010, next cycle oEX_VALID=1, oEX_SEL=1, exe_ptr+1, count 3.
REQ-036 SHALL verify: iEX_BUSY=1 with MATCHING=0001 -> oENTRY_EXOUT=0, exe_ptr unchanged; drop busy -> issue entry 0 next cycle.
REQ-037 SHALL verify: count=2, simultaneous regist and issue -> count stays 2, both pointers +1.
REQ-038 SHALL verify: 20 regist/issue pairs -> reg_ptr and exe_ptr wrap 15->0 and remain equal.
REQ-039 SHALL verify: iFLUSH with count=3 and pending issue -> oREMOVE_VALID=1 that cycle, no EXOUT, next cycle pointers=0, count=0, oREGIST_FULL=1 for FLUSH cycle, then RUN.
